// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: scoreboard slot layout,
// memory-access FSM states and common widths.
package pipe_ctrl_pkg;

   localparam int REG_W       = 4;
   localparam int STALL_CNT_W = 16;

   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic [REG_W-1:0] dest;
      logic             mem_read;
      logic             mem_write;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Sequences one SRAM access from the MEM stage: freezes the pipe while the
// request is outstanding, abandons it after TIMEOUT_CYCLES and signals an error.
module mem_access_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_op,
   input  logic sram_ready,
   output logic freeze,
   output logic sram_req,
   output logic sram_error
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   mem_state_t state_reg, state_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      freeze        = 1'b0;
      sram_req      = 1'b0;
      sram_error    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (mem_op) begin
               freeze     = 1'b1;
               sram_req   = 1'b1;
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            freeze   = 1'b1;
            sram_req = 1'b1;
            if (sram_ready) begin
               state_next    = ST_DONE;
               wait_cnt_next = 8'd0;
            end else if (wait_cnt_reg == LAST_WAIT) begin
               sram_error    = 1'b1;
               state_next    = ST_DONE;
               wait_cnt_next = 8'd0;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         // DONE always returns to IDLE so the retiring access is never re-issued
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (rst) begin
         freeze     = 1'b0;
         sram_req   = 1'b0;
         sram_error = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 8'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: EXE/MEM destination scoreboard, RAW hazard
// detection for ID, branch flush, SRAM freeze sequencing and stall counting.
module hazard_scheduler
   import pipe_ctrl_pkg::*;
#(
   parameter int FWD_EN         = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_W-1:0]       id_src1,
   input  logic [REG_W-1:0]       id_src2,
   input  logic                   id_src1_used,
   input  logic                   id_src2_used,
   input  logic [REG_W-1:0]       id_dest,
   input  logic                   id_wb_en,
   input  logic                   id_mem_read,
   input  logic                   id_mem_write,
   input  logic                   br_taken,
   input  logic                   sram_ready,
   output logic                   hazard,
   output logic                   freeze_front,
   output logic                   freeze_pipe,
   output logic                   flush,
   output logic                   sram_req,
   output logic                   sram_error,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   slot_t                  exe_slot_reg, mem_slot_reg, exe_slot_next;
   slot_t                  slot_vec [2];
   logic [1:0]             slot_hit;
   logic                   hazard_raw;
   logic                   mem_op;
   logic [STALL_CNT_W-1:0] stall_cnt_reg;

   assign slot_vec[0] = exe_slot_reg;
   assign slot_vec[1] = mem_slot_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
         assign slot_hit[gi] = slot_vec[gi].valid & slot_vec[gi].wb_en &
            ((id_src1_used & (id_src1 == slot_vec[gi].dest)) |
             (id_src2_used & (id_src2 == slot_vec[gi].dest)));
      end
   endgenerate

   // With forwarding only a load still in EXE cannot supply its result in time
   assign hazard_raw   = (FWD_EN != 0) ? (slot_hit[0] & exe_slot_reg.mem_read) : (|slot_hit);
   assign hazard       = ~rst & ~br_taken & hazard_raw;
   assign flush        = ~rst & br_taken & ~freeze_pipe;
   assign freeze_front = hazard | freeze_pipe;
   assign mem_op       = mem_slot_reg.valid & (mem_slot_reg.mem_read | mem_slot_reg.mem_write);
   assign stall_cycles = stall_cnt_reg;

   mem_access_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_mem_fsm (
      .clk       (clk),
      .rst       (rst),
      .mem_op    (mem_op),
      .sram_ready(sram_ready),
      .freeze    (freeze_pipe),
      .sram_req  (sram_req),
      .sram_error(sram_error)
   );

   always_comb begin
      exe_slot_next           = '0;
      exe_slot_next.valid     = 1'b1;
      exe_slot_next.wb_en     = id_wb_en;
      exe_slot_next.dest      = id_dest;
      exe_slot_next.mem_read  = id_mem_read;
      exe_slot_next.mem_write = id_mem_write;
      if (hazard | flush) begin
         exe_slot_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_slot_reg <= '0;
         mem_slot_reg <= '0;
      end else if (!freeze_pipe) begin
         mem_slot_reg <= exe_slot_reg;
         exe_slot_reg <= exe_slot_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (freeze_front && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
      end
   end

endmodule
